mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory backend between the IF-stage fetch port (port I) and MEM-stage load/store port (port D).

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/mem_arb_pick.sv | 30 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, port owner ids and watchdog width.
package mem_arb_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_RESP} arb_state_t;
   typedef enum logic {OWN_I, OWN_D} arb_owner_t;

   localparam int TO_W = 16;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch (I) and load/store (D) ports.
// Define MEM_ARB_RR_EN for round-robin; otherwise D always beats I.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic       ifReq,
   input  logic       dReq,
`ifdef MEM_ARB_RR_EN
   input  arb_owner_t lastOwner,
`endif
   output arb_owner_t winner
);

   // With no request the result is unused, so D is a harmless default.
   always_comb begin
      winner = OWN_D;
`ifdef MEM_ARB_RR_EN
      if (ifReq && dReq) begin
         winner = (lastOwner == OWN_D) ? OWN_I : OWN_D;
      end else if (ifReq) begin
         winner = OWN_I;
      end
`else
      if (ifReq && !dReq) begin
         winner = OWN_I;
      end
`endif
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the load/store port,
// one transaction at a time, with a response watchdog. Optional macro: MEM_ARB_RR_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic            if_done,
   output logic [DW-1:0]   if_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_wstrb,
   output logic            d_done,
   output logic [DW-1:0]   d_rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wstrb,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [DW-1:0]   mem_rdata,
   output logic            err
);

   localparam logic [TO_W-1:0] timeoutLimit = TO_W'(TIMEOUT);

   arb_state_t      state;
   arb_owner_t      owner;
   arb_owner_t      winner;
   logic [TO_W-1:0] waitCount;
   logic            anyReq;

   assign anyReq = if_req | d_req;

`ifdef MEM_ARB_RR_EN
   arb_owner_t lastOwner;

   mem_arb_pick uPick (
      .ifReq     (if_req),
      .dReq      (d_req),
      .lastOwner (lastOwner),
      .winner    (winner)
   );
`else
   mem_arb_pick uPick (
      .ifReq  (if_req),
      .dReq   (d_req),
      .winner (winner)
   );
`endif

   // The mem_* outputs double as the latched request fields, so they stay stable
   // for the whole REQ phase; done/rdata are cleared every cycle except the RESP cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ARB_IDLE;
         owner     <= OWN_I;
         waitCount <= '0;
         if_done   <= 1'b0;
         if_rdata  <= '0;
         d_done    <= 1'b0;
         d_rdata   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         err       <= 1'b0;
`ifdef MEM_ARB_RR_EN
         lastOwner <= OWN_D;
`endif
      end else begin
         if_done  <= 1'b0;
         d_done   <= 1'b0;
         if_rdata <= '0;
         d_rdata  <= '0;
         case (state)
            ARB_IDLE: begin
               if (anyReq) begin
                  state   <= ARB_REQ;
                  owner   <= winner;
                  mem_req <= 1'b1;
`ifdef MEM_ARB_RR_EN
                  lastOwner <= winner;
`endif
                  if (winner == OWN_D) begin
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                     mem_wstrb <= d_we ? d_wstrb : '0;
                  end else begin
                     mem_we    <= 1'b0;
                     mem_addr  <= if_addr;
                     mem_wdata <= '0;
                     mem_wstrb <= '0;
                  end
               end
            end
            ARB_REQ: begin
               if (mem_gnt) begin
                  state     <= ARB_WAIT;
                  mem_req   <= 1'b0;
                  waitCount <= '0;
               end
            end
            // A real response wins over a watchdog expiry landing in the same cycle.
            ARB_WAIT: begin
               if (mem_rvalid || (waitCount == timeoutLimit)) begin
                  state     <= ARB_RESP;
                  waitCount <= '0;
                  if (owner == OWN_D) begin
                     d_done  <= 1'b1;
                     d_rdata <= (mem_rvalid && !mem_we) ? mem_rdata : '0;
                  end else begin
                     if_done  <= 1'b1;
                     if_rdata <= mem_rvalid ? mem_rdata : '0;
                  end
                  if (!mem_rvalid) begin
                     err <= 1'b1;
                  end
               end else begin
                  waitCount <= waitCount + 1'b1;
               end
            end
            ARB_RESP: begin
               state <= ARB_IDLE;
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TIMEOUT = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            if_req;
   logic [AW-1:0]   if_addr;
   logic            if_done;
   logic [DW-1:0]   if_rdata;
   logic            d_req;
   logic            d_we;
   logic [AW-1:0]   d_addr;
   logic [DW-1:0]   d_wdata;
   logic [DW/8-1:0] d_wstrb;
   logic            d_done;
   logic [DW-1:0]   d_rdata;
   logic            mem_req;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW/8-1:0] mem_wstrb;
   logic            mem_gnt;
   logic            mem_rvalid;
   logic [DW-1:0]   mem_rdata;
   logic            err;

   int vectors = 0;
   int miscompares = 0;

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_done    (if_done),
      .if_rdata   (if_rdata),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_wstrb    (d_wstrb),
      .d_done     (d_done),
      .d_rdata    (d_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Model of the one outstanding transaction: issued, granted, answered.
   bit              mBusy, mGranted, mAnswered, mOwnD, mLastD;
   int              mWaitAge;
   logic            mWe;
   logic [AW-1:0]   mAddr;
   logic [DW-1:0]   mWdata;
   logic [DW/8-1:0] mStrb;
   bit              expIfDone, expDDone, expErr;
   logic [DW-1:0]   expIfRdata, expDRdata;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mBusy = 0; mGranted = 0; mAnswered = 0; mOwnD = 0; mLastD = 1;
         mWaitAge = 0; mWe = 0; mAddr = '0; mWdata = '0; mStrb = '0;
         expIfDone = 0; expDDone = 0; expErr = 0; expIfRdata = '0; expDRdata = '0;
      end else begin
         expIfDone = 0; expDDone = 0; expIfRdata = '0; expDRdata = '0;
         if (mAnswered) begin
            mAnswered = 0;
            mBusy = 0;
         end else if (!mBusy) begin
            if (if_req || d_req) begin
`ifdef MEM_ARB_RR_EN
               mOwnD = (if_req && d_req) ? !mLastD : d_req;
`else
               mOwnD = d_req;
`endif
               mLastD = mOwnD;
               mBusy = 1;
               mGranted = 0;
               mWe    = mOwnD ? d_we : 1'b0;
               mAddr  = mOwnD ? d_addr : if_addr;
               mWdata = mOwnD ? d_wdata : '0;
               mStrb  = (mOwnD && d_we) ? d_wstrb : '0;
            end
         end else if (!mGranted) begin
            if (mem_gnt) begin
               mGranted = 1;
               mWaitAge = 0;
            end
         end else if (mem_rvalid || mWaitAge == TIMEOUT) begin
            mAnswered = 1;
            if (mOwnD) begin
               expDDone = 1;
               expDRdata = (mem_rvalid && !mWe) ? mem_rdata : '0;
            end else begin
               expIfDone = 1;
               expIfRdata = mem_rvalid ? mem_rdata : '0;
            end
            if (!mem_rvalid) expErr = 1;
         end else begin
            mWaitAge++;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Every output against the model, once per cycle on the falling edge.
   always @(negedge clk) begin
      checkOutput("mem_req",   32'(mem_req),   32'(mBusy && !mGranted && !mAnswered));
      checkOutput("mem_we",    32'(mem_we),    32'(mWe));
      checkOutput("mem_addr",  mem_addr,       mAddr);
      checkOutput("mem_wdata", mem_wdata,      mWdata);
      checkOutput("mem_wstrb", 32'(mem_wstrb), 32'(mStrb));
      checkOutput("if_done",   32'(if_done),   32'(expIfDone));
      checkOutput("if_rdata",  if_rdata,       expIfRdata);
      checkOutput("d_done",    32'(d_done),    32'(expDDone));
      checkOutput("d_rdata",   d_rdata,        expDRdata);
      checkOutput("err",       32'(err),       32'(expErr));
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                                input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] ds);
      if_req = ir; if_addr = ia;
      d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_wstrb = ds;
   endtask

   // Starts in the first REQ cycle; grants after gntDelay cycles, answers the next
   // cycle, and returns in the RESP cycle.
   task automatic backend(input int gntDelay, input logic [31:0] rdata);
      mem_gnt = 1'b0;
      repeat (gntDelay) step();
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = rdata;
      step();
      mem_rvalid = 1'b0;
      mem_rdata = '0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] stopped");
   end

   initial begin
      int n;
      bit found;
      reset = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
      step();
      @(negedge clk);
      checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
      checkOutput("reset_err", 32'(err), 32'd0);
      step();
      reset = 1'b1;
      step();

      // Single fetch, minimum latency.
      applyStimulus(1, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0);
      step();
      @(negedge clk);
      checkOutput("t1_mem_req", 32'(mem_req), 32'd1);
      checkOutput("t1_mem_addr", mem_addr, 32'h100);
      step();
      backend(0, 32'hDEADBEEF);
      @(negedge clk);
      checkOutput("t1_if_done", 32'(if_done), 32'd1);
      checkOutput("t1_if_rdata", if_rdata, 32'hDEADBEEF);
      if_req = 1'b0;
      step();

      // Conflict: store goes first, fetch right behind it.
      applyStimulus(1, 32'h104, 1, 1, 32'h200, 32'h12345678, 4'hF);
      step();
      @(negedge clk);
      checkOutput("t2_store_addr", mem_addr, 32'h200);
      checkOutput("t2_store_wdata", mem_wdata, 32'h12345678);
      checkOutput("t2_store_wstrb", 32'(mem_wstrb), 32'hF);
      step();
      backend(0, 32'h55555555);
      @(negedge clk);
      checkOutput("t2_d_done", 32'(d_done), 32'd1);
      checkOutput("t2_d_rdata_store", d_rdata, 32'h0);
      checkOutput("t2_if_done_idle", 32'(if_done), 32'd0);
      d_req = 1'b0;
      step();
      step();
      @(negedge clk);
      checkOutput("t2_fetch_addr", mem_addr, 32'h104);
      checkOutput("t2_fetch_we", 32'(mem_we), 32'd0);
      checkOutput("t2_fetch_wstrb", 32'(mem_wstrb), 32'd0);
      step();
      backend(0, 32'h11112222);
      @(negedge clk);
      checkOutput("t2_if_rdata", if_rdata, 32'h11112222);
      if_req = 1'b0;
      step();

      // Grant held off 5 cycles, then a load returning 0xCAFEF00D.
      applyStimulus(0, 32'h0, 1, 0, 32'h300, 32'hA5A5A5A5, 4'hF);
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("t3_hold_req", 32'(mem_req), 32'd1);
         checkOutput("t3_hold_addr", mem_addr, 32'h300);
         checkOutput("t3_hold_wdata", mem_wdata, 32'hA5A5A5A5);
         checkOutput("t3_hold_done", 32'(d_done), 32'd0);
         step();
      end
      backend(0, 32'hCAFEF00D);
      @(negedge clk);
      checkOutput("t6_d_done", 32'(d_done), 32'd1);
      checkOutput("t6_d_rdata", d_rdata, 32'hCAFEF00D);
      checkOutput("t6_if_done", 32'(if_done), 32'd0);
      d_req = 1'b0;
      step();

      // Lost response: watchdog ends the fetch with zero data and sets err.
      applyStimulus(1, 32'h400, 0, 0, 32'h0, 32'h0, 4'h0);
      step();
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      n = 0;
      found = 0;
      while (!found && n < 20) begin
         @(negedge clk);
         if (if_done) found = 1;
         else begin
            n++;
            step();
         end
      end
      checkOutput("t4_timeout_cycles", 32'(n), 32'(TIMEOUT + 1));
      checkOutput("t4_if_rdata", if_rdata, 32'h0);
      checkOutput("t4_err", 32'(err), 32'd1);
      if_req = 1'b0;
      step();
      mem_rvalid = 1'b1;
      mem_rdata = 32'h0BADF00D;
      step();
      @(negedge clk);
      checkOutput("t4_stale_if_done", 32'(if_done), 32'd0);
      step();
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      step();

      // Reset in the middle of WAIT, then a late response.
      applyStimulus(0, 32'h0, 1, 1, 32'h500, 32'h99887766, 4'h3);
      step();
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      step();
      reset = 1'b0;
      #1;
      checkOutput("t5_async_addr", mem_addr, 32'h0);
      checkOutput("t5_async_wstrb", 32'(mem_wstrb), 32'h0);
      checkOutput("t5_async_err", 32'(err), 32'd0);
      d_req = 1'b0;
      step();
      step();
      reset = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata = 32'h00000077;
      step();
      @(negedge clk);
      checkOutput("t5_late_d_done", 32'(d_done), 32'd0);
      step();
      @(negedge clk);
      checkOutput("t5_late_d_done2", 32'(d_done), 32'd0);
      mem_rvalid = 1'b0;
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
